sram_like_arbiter: RTL and testbench

- Shares the single sram-like memory port toward the AXI bridge between the I-cache master and the D-cache master.
- Grants one transaction at a time and holds the grant from request through data_ok.
- Routes the handshake back to the owning master only.
- D-cache has fixed priority, with a starvation limit that forces an I-cache grant.

---
 rtl/axi_sram_pkg.sv | 18 +
 rtl/sram_like_mux2.sv | 27 ++
 rtl/sram_like_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared encodings for the sram-like port arbiter: FSM state codes and access sizes.
package axi_sram_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ADDR = 2'b01;
    localparam logic [1:0] DATA = 2'b10;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ADDR = ADDR,
        ST_DATA = DATA
    } state_t;

endpackage

// File: rtl/sram_like_mux2.sv
// Pure request-field mux: selects the I-cache (sel_d=0) or D-cache (sel_d=1) request fields.
module sram_like_mux2 (
    input  logic        sel_d,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata
);

    assign m_req   = sel_d ? d_req   : i_req;
    assign m_wr    = sel_d ? d_wr    : i_wr;
    assign m_size  = sel_d ? d_size  : i_size;
    assign m_addr  = sel_d ? d_addr  : i_addr;
    assign m_wdata = sel_d ? d_wdata : i_wdata;

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master arbiter for one sram-like port: D-cache priority, starvation limit for I-cache,
// one outstanding transaction held from grant through data_ok.
module sram_like_arbiter
    import axi_sram_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        busy,
    output logic        owner_d
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state_reg, state_next;
    logic             owner_d_reg, owner_d_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    logic win_i, win_d, any_req, sel_d, m_req;

    assign any_req = i_req | d_req;
    assign win_i   = i_req & (~d_req | (starve_cnt_reg == CNT_MAX));
    assign win_d   = d_req & ~win_i;
    // In IDLE the live winner drives the port; afterwards the latched owner does.
    assign sel_d   = (state_reg == ST_IDLE) ? win_d : owner_d_reg;

    sram_like_mux2 u_mux (
        .sel_d   (sel_d),
        .i_req   (i_req),
        .i_wr    (i_wr),
        .i_size  (i_size),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .m_req   (m_req),
        .m_wr    (s_wr),
        .m_size  (s_size),
        .m_addr  (s_addr),
        .m_wdata (s_wdata)
    );

    assign i_rdata = s_rdata;
    assign d_rdata = s_rdata;
    assign busy    = (state_reg != ST_IDLE);
    assign owner_d = owner_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_d_reg    <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_d_reg    <= owner_d_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_d_next    = owner_d_reg;
        starve_cnt_next = starve_cnt_reg;
        s_req           = 1'b0;
        i_addr_ok       = 1'b0;
        d_addr_ok       = 1'b0;
        i_data_ok       = 1'b0;
        d_data_ok       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                s_req = any_req;
                if (any_req) begin
                    owner_d_next = win_d;
                    // Count only D grants that actually made a waiting I-cache wait longer.
                    if (win_d && i_req)
                        starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? CNT_MAX
                                                                      : starve_cnt_reg + CNT_W'(1);
                    else
                        starve_cnt_next = '0;
                    i_addr_ok = s_addr_ok & win_i;
                    d_addr_ok = s_addr_ok & win_d;
                    i_data_ok = s_addr_ok & s_data_ok & win_i;
                    d_data_ok = s_addr_ok & s_data_ok & win_d;
                    if (s_addr_ok)
                        state_next = s_data_ok ? ST_IDLE : ST_DATA;
                    else
                        state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s_req     = m_req;
                i_addr_ok = s_addr_ok & ~owner_d_reg;
                d_addr_ok = s_addr_ok & owner_d_reg;
                i_data_ok = s_addr_ok & s_data_ok & ~owner_d_reg;
                d_data_ok = s_addr_ok & s_data_ok & owner_d_reg;
                if (s_addr_ok)
                    state_next = s_data_ok ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                i_data_ok = s_data_ok & ~owner_d_reg;
                d_data_ok = s_data_ok & owner_d_reg;
                if (s_data_ok)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs driven on negedge, outputs checked 1ns later.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_addr_ok, s_data_ok;
    logic        busy, owner_d;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .busy(busy), .owner_d(owner_d)
    );

    task automatic clear_inputs();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 0; d_wdata = 0;
        s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;
    endtask

    // Both masters request, bridge completes in the grant cycle; records 1 for a D grant.
    task automatic run_grants(input int n, output logic [15:0] seq);
        seq = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_req = 1; d_req = 1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
            s_addr_ok = 1; s_data_ok = 1;
            #1 seq[k] = d_addr_ok;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        #1;
        n_checks++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL reset_s_req got=%b want=0", s_req); end
        n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (owner_d !== 1'b0) begin n_bad++; $display("FAIL reset_owner got=%b want=0", owner_d); end
        n_checks++; if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0) begin
            n_bad++; $display("FAIL reset_hs got=%b want=0000", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}); end
        $display("txn reset released");
    endtask

    task automatic test_single_d_read();
        @(negedge clk);
        d_req = 1; d_addr = 32'h0000_1000; s_addr_ok = 1;
        #1;
        n_checks++; if (s_addr !== 32'h1000 || s_req !== 1'b1) begin n_bad++;
            $display("FAIL d_read_addr got=%h/%b want=00001000/1", s_addr, s_req); end
        n_checks++; if ({d_addr_ok, i_addr_ok, d_data_ok} !== 3'b100) begin n_bad++;
            $display("FAIL d_read_addr_ok got=%b want=100", {d_addr_ok, i_addr_ok, d_data_ok}); end
        @(negedge clk);
        d_req = 0; s_addr_ok = 0;
        #1;
        n_checks++; if (busy !== 1'b1 || s_req !== 1'b0) begin n_bad++;
            $display("FAIL d_read_data_wait got=%b/%b want=1/0", busy, s_req); end
        @(negedge clk);
        @(negedge clk);
        s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (d_data_ok !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL d_read_data got=%b/%h want=1/deadbeef", d_data_ok, d_rdata); end
        n_checks++; if (i_data_ok !== 1'b0 || i_addr_ok !== 1'b0) begin n_bad++;
            $display("FAIL d_read_i_quiet got=%b/%b want=0/0", i_data_ok, i_addr_ok); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL d_read_idle got=%b want=0", busy); end
        $display("txn single D read addr=00001000 rdata=%h", d_rdata);
    endtask

    task automatic test_priority();
        @(negedge clk);
        i_req = 1; i_addr = 32'h2000; d_req = 1; d_addr = 32'h3000; s_addr_ok = 1;
        #1;
        n_checks++; if (s_addr !== 32'h3000 || d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin n_bad++;
            $display("FAIL prio_first got=%h/%b/%b want=00003000/1/0", s_addr, d_addr_ok, i_addr_ok); end
        @(negedge clk);
        d_req = 0; s_addr_ok = 0;
        #1;
        n_checks++; if (s_req !== 1'b0 || i_addr_ok !== 1'b0) begin n_bad++;
            $display("FAIL prio_data_hold got=%b/%b want=0/0", s_req, i_addr_ok); end
        @(negedge clk);
        s_data_ok = 1; s_addr_ok = 1;
        #1;
        n_checks++; if ({d_data_ok, i_data_ok, i_addr_ok} !== 3'b100) begin n_bad++;
            $display("FAIL prio_d_done got=%b want=100", {d_data_ok, i_data_ok, i_addr_ok}); end
        @(negedge clk);
        s_data_ok = 0; s_addr_ok = 1;
        #1;
        n_checks++; if (s_addr !== 32'h2000 || i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin n_bad++;
            $display("FAIL prio_second got=%h/%b/%b want=00002000/1/0", s_addr, i_addr_ok, d_addr_ok); end
        @(negedge clk);
        i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h1111_2222;
        #1;
        n_checks++; if (i_data_ok !== 1'b1 || d_data_ok !== 1'b0 || owner_d !== 1'b0) begin n_bad++;
            $display("FAIL prio_i_done got=%b/%b/%b want=1/0/0", i_data_ok, d_data_ok, owner_d); end
        @(negedge clk);
        clear_inputs();
        $display("txn priority D then I");
    endtask

    task automatic test_delayed_addr();
        @(negedge clk);
        d_req = 1; d_wr = 1; d_addr = 32'h4000; d_wdata = 32'h1234_5678;
        #1;
        n_checks++; if (d_addr_ok !== 1'b0 || s_req !== 1'b1) begin n_bad++;
            $display("FAIL delay_c0 got=%b/%b want=0/1", d_addr_ok, s_req); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            i_req = 1; i_addr = 32'h5000;
            s_data_ok = (k == 2);
            #1;
            n_checks++; if (busy !== 1'b1 || s_req !== 1'b1 || s_wr !== 1'b1 || s_wdata !== 32'h12345678
                            || s_addr !== 32'h4000) begin n_bad++;
                $display("FAIL delay_hold%0d got=%b/%b/%b/%h/%h want=1/1/1/12345678/00004000",
                         k, busy, s_req, s_wr, s_wdata, s_addr); end
            n_checks++; if ({i_addr_ok, d_addr_ok, d_data_ok} !== 3'b000) begin n_bad++;
                $display("FAIL delay_quiet%0d got=%b want=000", k, {i_addr_ok, d_addr_ok, d_data_ok}); end
        end
        @(negedge clk);
        s_data_ok = 0; s_addr_ok = 1;
        #1;
        n_checks++; if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0 || busy !== 1'b1) begin n_bad++;
            $display("FAIL delay_accept got=%b/%b/%b want=1/0/1", d_addr_ok, i_addr_ok, busy); end
        @(negedge clk);
        d_req = 0; i_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        n_checks++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin n_bad++;
            $display("FAIL delay_done got=%b/%b want=1/0", d_data_ok, i_data_ok); end
        @(negedge clk);
        clear_inputs();
        $display("txn delayed addr_ok D write wdata=12345678");
    endtask

    task automatic test_combined();
        @(negedge clk);
        d_req = 1; d_addr = 32'h6000; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if ({d_addr_ok, d_data_ok} !== 2'b11 || d_rdata !== 32'hCAFEF00D) begin n_bad++;
            $display("FAIL comb_hs got=%b/%h want=11/cafef00d", {d_addr_ok, d_data_ok}, d_rdata); end
        n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL comb_busy got=%b want=0", busy); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (busy !== 1'b0 || owner_d !== 1'b1) begin n_bad++;
            $display("FAIL comb_after got=%b/%b want=0/1", busy, owner_d); end
        $display("txn combined handshake D read");
    endtask

    task automatic test_starvation();
        logic [15:0] seq;
        logic [9:0]  exp_seq;
        exp_seq = 10'b0111101111; // bit k = grant k is D; order D,D,D,D,I,D,D,D,D,I
        run_grants(10, seq);
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (seq[k] !== exp_seq[k]) begin n_bad++;
                $display("FAIL starve_grant%0d got_d=%b want_d=%b", k, seq[k], exp_seq[k]); end
        end
        $display("txn starvation sequence d_bits=%b", seq[9:0]);
    endtask

    task automatic test_reset_mid();
        logic [15:0] seq;
        run_grants(3, seq);   // starve_cnt now 3
        @(negedge clk);
        i_req = 1; d_req = 1; s_addr_ok = 1;   // 4th D grant, parks in DATA
        @(negedge clk);
        clear_inputs(); rst = 1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got=%b want=1", busy); end
        @(negedge clk);
        rst = 0; s_data_ok = 1;
        #1;
        n_checks++; if ({i_data_ok, d_data_ok, busy} !== 3'b000) begin n_bad++;
            $display("FAIL rstmid_stray got=%b want=000", {i_data_ok, d_data_ok, busy}); end
        @(negedge clk);
        s_data_ok = 0;
        #1;
        n_checks++; if (busy !== 1'b0 || owner_d !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_idle got=%b/%b want=0/0", busy, owner_d); end
        run_grants(5, seq);
        n_checks++; if (seq[4:0] !== 5'b01111) begin n_bad++;
            $display("FAIL rstmid_cnt got=%b want=01111", seq[4:0]); end
        $display("txn reset mid-transaction");
    endtask

    initial begin
        test_reset();
        test_single_d_read();
        test_priority();
        test_delayed_addr();
        test_combined();
        test_starvation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
